// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/LSU/memory port bundle shared by the arbiter and its neighbours
interface mem_port_arbiter_if;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic [31:0] instr_rdata;
  logic        instr_err;
  logic        instr_valid;

  logic        data_req;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic [31:0] data_rdata;
  logic        data_err;
  logic        data_valid;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        mem_valid;

  // Arbiter view: serves the two core masters and drives the memory port.
  modport slave (
    input  instr_req, instr_addr,
    input  data_req, data_addr, data_we, data_be, data_wdata,
    input  mem_gnt, mem_rdata, mem_err, mem_valid,
    output instr_gnt, instr_rdata, instr_err, instr_valid,
    output data_gnt, data_rdata, data_err, data_valid,
    output mem_req, mem_addr, mem_we, mem_be, mem_wdata
  );

  // Environment view: core requesters plus the memory itself.
  modport master (
    output instr_req, instr_addr,
    output data_req, data_addr, data_we, data_be, data_wdata,
    output mem_gnt, mem_rdata, mem_err, mem_valid,
    input  instr_gnt, instr_rdata, instr_err, instr_valid,
    input  data_gnt, data_rdata, data_err, data_valid,
    input  mem_req, mem_addr, mem_we, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-master arbiter for a single req/gnt/valid memory port
module mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ARB_MODE        = 0
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  mem_port_arbiter_if.slave                    bus,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 resp_orphan
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam logic ID_INSTR = 1'b0;
  localparam logic ID_DATA  = 1'b1;

  typedef enum logic {ARB_IDLE, ARB_LOCK} state_e;

  state_e                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   last_q, last_d;
  logic [MAX_OUTSTANDING-1:0] id_q;
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          cnt_q;
  logic                   orphan_q;

  logic full, sel_vld, sel_id, push, pop, head_id, owner_req, orphan_set;

  assign full       = (cnt_q == CW'(MAX_OUTSTANDING));
  assign owner_req  = owner_q ? bus.data_req : bus.instr_req;
  assign head_id    = id_q[rd_ptr_q];
  assign pop        = reset_n && bus.mem_valid && (cnt_q != '0);
  assign orphan_set = reset_n && bus.mem_valid && (cnt_q == '0);

  // Pick the requester for this cycle and decide whether to hold it until memory accepts.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    sel_vld = 1'b0;
    sel_id  = ID_INSTR;
    push    = 1'b0;
    if (reset_n) begin
      case (state_q)
        ARB_IDLE: begin
          if (!full && (bus.instr_req || bus.data_req)) begin
            sel_vld = 1'b1;
            if (ARB_MODE == 0)
              sel_id = bus.data_req ? ID_DATA : ID_INSTR;
            else if (bus.instr_req && bus.data_req)
              sel_id = ~last_q;
            else
              sel_id = bus.data_req ? ID_DATA : ID_INSTR;
            if (bus.mem_gnt) begin
              push = 1'b1;
            end else begin
              state_d = ARB_LOCK;
              owner_d = sel_id;
            end
          end
        end
        ARB_LOCK: begin
          sel_id = owner_q;
          if (!owner_req) begin
            // Owner withdrew before the grant: abandon the request without tracking it.
            state_d = ARB_IDLE;
          end else if (!full) begin
            sel_vld = 1'b1;
            if (bus.mem_gnt) begin
              push    = 1'b1;
              state_d = ARB_IDLE;
            end
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
    if (push) last_d = sel_id;
  end

  // Request and response muxing toward memory and back to the requesters.
  always_comb begin
    bus.mem_req     = sel_vld;
    bus.mem_addr    = !sel_vld ? 32'h0 : (sel_id ? bus.data_addr : bus.instr_addr);
    bus.mem_we      = sel_vld && sel_id && bus.data_we;
    bus.mem_be      = !sel_vld ? 4'h0 : (sel_id ? bus.data_be : 4'hF);
    bus.mem_wdata   = (sel_vld && sel_id) ? bus.data_wdata : 32'h0;
    bus.instr_gnt   = push && (sel_id == ID_INSTR);
    bus.data_gnt    = push && (sel_id == ID_DATA);
    bus.instr_valid = pop && (head_id == ID_INSTR);
    bus.data_valid  = pop && (head_id == ID_DATA);
    bus.instr_rdata = bus.instr_valid ? bus.mem_rdata : 32'h0;
    bus.data_rdata  = bus.data_valid ? bus.mem_rdata : 32'h0;
    bus.instr_err   = bus.instr_valid && bus.mem_err;
    bus.data_err    = bus.data_valid && bus.mem_err;
  end

  // State, round-robin history, in-order ID FIFO and the sticky orphan flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ARB_IDLE;
      owner_q  <= ID_INSTR;
      last_q   <= ID_INSTR;
      id_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      orphan_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      if (push) begin
        id_q[wr_ptr_q] <= sel_id;
        wr_ptr_q       <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      if (orphan_set) orphan_q <= 1'b1;
    end
  end

  assign outstanding = cnt_q;
  assign resp_orphan = orphan_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized model-checked bench for both arbitration modes
module tb_mem_port_arbiter;
  localparam int MAXO = 4;
  localparam int CW   = $clog2(MAXO + 1);

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if if_fp ();
  mem_port_arbiter_if if_rr ();
  logic [CW-1:0] out_fp, out_rr;
  logic          orph_fp, orph_rr;

  mem_port_arbiter #(.MAX_OUTSTANDING(MAXO), .ARB_MODE(0)) u_dut_fp (
    .clk(clk), .reset_n(reset_n), .bus(if_fp), .outstanding(out_fp), .resp_orphan(orph_fp)
  );
  mem_port_arbiter #(.MAX_OUTSTANDING(MAXO), .ARB_MODE(1)) u_dut_rr (
    .clk(clk), .reset_n(reset_n), .bus(if_rr), .outstanding(out_rr), .resp_orphan(orph_rr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // stimulus per instance (0 = fixed priority, 1 = round robin)
  logic        ireq[2], dreq[2], dwe[2], mgnt[2], merr[2], mval[2];
  logic [31:0] iaddr[2], daddr[2], dwdata[2], mrdata[2];
  logic [3:0]  dbe[2];

  typedef struct {
    logic        ig, dg, iv, dv, ie, de, mreq, mwe, orph;
    logic [31:0] ird, drd, maddr, mwd;
    logic [3:0]  mbe;
    logic [CW-1:0] outs;
  } obs_t;
  obs_t ob[2];

  // reference model: queue of requester IDs in flight, pending owner (-1 none, 0 instr, 1 data)
  int idq[2][$];
  int pend[2], last[2], sel[2];
  bit morph[2], gexp[2];

  task automatic drive();
    if_fp.instr_req = ireq[0]; if_fp.instr_addr = iaddr[0];
    if_fp.data_req = dreq[0]; if_fp.data_addr = daddr[0]; if_fp.data_we = dwe[0];
    if_fp.data_be = dbe[0]; if_fp.data_wdata = dwdata[0];
    if_fp.mem_gnt = mgnt[0]; if_fp.mem_rdata = mrdata[0]; if_fp.mem_err = merr[0]; if_fp.mem_valid = mval[0];
    if_rr.instr_req = ireq[1]; if_rr.instr_addr = iaddr[1];
    if_rr.data_req = dreq[1]; if_rr.data_addr = daddr[1]; if_rr.data_we = dwe[1];
    if_rr.data_be = dbe[1]; if_rr.data_wdata = dwdata[1];
    if_rr.mem_gnt = mgnt[1]; if_rr.mem_rdata = mrdata[1]; if_rr.mem_err = merr[1]; if_rr.mem_valid = mval[1];
  endtask

  task automatic sample();
    ob[0].ig = if_fp.instr_gnt; ob[0].dg = if_fp.data_gnt; ob[0].iv = if_fp.instr_valid;
    ob[0].dv = if_fp.data_valid; ob[0].ie = if_fp.instr_err; ob[0].de = if_fp.data_err;
    ob[0].ird = if_fp.instr_rdata; ob[0].drd = if_fp.data_rdata; ob[0].mreq = if_fp.mem_req;
    ob[0].maddr = if_fp.mem_addr; ob[0].mwe = if_fp.mem_we; ob[0].mbe = if_fp.mem_be;
    ob[0].mwd = if_fp.mem_wdata; ob[0].outs = out_fp; ob[0].orph = orph_fp;
    ob[1].ig = if_rr.instr_gnt; ob[1].dg = if_rr.data_gnt; ob[1].iv = if_rr.instr_valid;
    ob[1].dv = if_rr.data_valid; ob[1].ie = if_rr.instr_err; ob[1].de = if_rr.data_err;
    ob[1].ird = if_rr.instr_rdata; ob[1].drd = if_rr.data_rdata; ob[1].mreq = if_rr.mem_req;
    ob[1].maddr = if_rr.mem_addr; ob[1].mwe = if_rr.mem_we; ob[1].mbe = if_rr.mem_be;
    ob[1].mwd = if_rr.mem_wdata; ob[1].outs = out_rr; ob[1].orph = orph_rr;
  endtask

  // Which requester should own the port this cycle, from the arbitration rules.
  task automatic predict(input int m);
    sel[m] = -1;
    if (reset_n && idq[m].size() < MAXO) begin
      if (pend[m] >= 0) begin
        if ((pend[m] == 0) ? ireq[m] : dreq[m]) sel[m] = pend[m];
      end else if (ireq[m] && dreq[m]) begin
        sel[m] = (m == 0) ? 1 : 1 - last[m];
      end else if (ireq[m] || dreq[m]) begin
        sel[m] = dreq[m] ? 1 : 0;
      end
    end
    gexp[m] = (sel[m] >= 0) && mgnt[m];
  endtask

  task automatic check_outputs(input int m);
    string p;
    int head;
    p = (m == 0) ? "fp" : "rr";
    check({p, ".mem_req"}, 32'(ob[m].mreq), 32'(sel[m] >= 0));
    check({p, ".instr_gnt"}, 32'(ob[m].ig), 32'(gexp[m] && sel[m] == 0));
    check({p, ".data_gnt"}, 32'(ob[m].dg), 32'(gexp[m] && sel[m] == 1));
    if (sel[m] == 0) begin
      check({p, ".mem_addr_i"}, ob[m].maddr, iaddr[m]);
      check({p, ".mem_we_i"}, 32'(ob[m].mwe), 32'h0);
      check({p, ".mem_be_i"}, 32'(ob[m].mbe), 32'hF);
      check({p, ".mem_wdata_i"}, ob[m].mwd, 32'h0);
    end else if (sel[m] == 1) begin
      check({p, ".mem_addr_d"}, ob[m].maddr, daddr[m]);
      check({p, ".mem_we_d"}, 32'(ob[m].mwe), 32'(dwe[m]));
      check({p, ".mem_be_d"}, 32'(ob[m].mbe), 32'(dbe[m]));
      check({p, ".mem_wdata_d"}, ob[m].mwd, dwdata[m]);
    end
    head = (reset_n && mval[m] && idq[m].size() > 0) ? idq[m][0] : -1;
    check({p, ".instr_valid"}, 32'(ob[m].iv), 32'(head == 0));
    check({p, ".data_valid"}, 32'(ob[m].dv), 32'(head == 1));
    check({p, ".instr_rdata"}, ob[m].ird, (head == 0) ? mrdata[m] : 32'h0);
    check({p, ".data_rdata"}, ob[m].drd, (head == 1) ? mrdata[m] : 32'h0);
    check({p, ".instr_err"}, 32'(ob[m].ie), 32'(head == 0 && merr[m]));
    check({p, ".data_err"}, 32'(ob[m].de), 32'(head == 1 && merr[m]));
    check({p, ".outstanding"}, 32'(ob[m].outs), 32'(idq[m].size()));
    check({p, ".resp_orphan"}, 32'(ob[m].orph), 32'(morph[m]));
  endtask

  // Commit what happened at the clock edge into the model.
  task automatic update(input int m);
    if (!reset_n) begin
      idq[m].delete();
      pend[m]  = -1;
      last[m]  = 0;
      morph[m] = 1'b0;
    end else begin
      if (mval[m]) begin
        if (idq[m].size() > 0) void'(idq[m].pop_front());
        else morph[m] = 1'b1;
      end
      if (gexp[m]) begin
        idq[m].push_back(sel[m]);
        last[m] = sel[m];
      end
      if (pend[m] >= 0) begin
        if (gexp[m] || sel[m] < 0) pend[m] = -1;
      end else if (sel[m] >= 0 && !mgnt[m]) begin
        pend[m] = sel[m];
      end
    end
  endtask

  task automatic gen(input int m, input int preq, input int pgnt, input int pval);
    if (!(ireq[m] && !(gexp[m] && sel[m] == 0) && $urandom_range(0, 15) != 0)) begin
      ireq[m]  = ($urandom_range(0, 99) < preq);
      iaddr[m] = $urandom() & 32'hFFFF_FFFC;
    end
    if (!(dreq[m] && !(gexp[m] && sel[m] == 1) && $urandom_range(0, 15) != 0)) begin
      dreq[m]   = ($urandom_range(0, 99) < preq);
      daddr[m]  = $urandom();
      dwe[m]    = $urandom_range(0, 1) == 1;
      dbe[m]    = 4'($urandom());
      dwdata[m] = $urandom();
    end
    mgnt[m]   = ($urandom_range(0, 99) < pgnt);
    mval[m]   = (idq[m].size() > 0) ? ($urandom_range(0, 99) < pval) : ($urandom_range(0, 99) < 2);
    mrdata[m] = $urandom();
    merr[m]   = ($urandom_range(0, 3) == 0);
  endtask

  int preq_t[4] = '{100, 60, 90, 30};
  int pgnt_t[4] = '{100, 40, 90, 70};
  int pval_t[4] = '{100, 50, 10, 90};
  int len_t[4]  = '{200, 400, 300, 200};

  initial begin
    reset_n = 1'b0;
    for (int m = 0; m < 2; m++) begin
      ireq[m] = 0; dreq[m] = 0; dwe[m] = 0; mgnt[m] = 0; merr[m] = 0; mval[m] = 0;
      iaddr[m] = 0; daddr[m] = 0; dwdata[m] = 0; mrdata[m] = 0; dbe[m] = 0;
      pend[m] = -1; last[m] = 0; sel[m] = -1; gexp[m] = 0; morph[m] = 0;
    end
    drive();
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < len_t[ph]; c++) begin
        @(posedge clk);
        for (int m = 0; m < 2; m++) update(m);
        #1;
        if (ph == 0 && c < 3) reset_n = 1'b0;
        else reset_n = (ph == 0) || ($urandom_range(0, 99) != 0);
        for (int m = 0; m < 2; m++) gen(m, preq_t[ph], pgnt_t[ph], pval_t[ph]);
        drive();
        #4;
        sample();
        for (int m = 0; m < 2; m++) begin
          predict(m);
          check_outputs(m);
        end
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one req/gnt/valid memory port between the instruction fetch unit and the load/store unit. Arbitrates new requests and holds the chosen requester until the memory grants it. Tracks in-order outstanding transactions in an ID FIFO so each response returns to the requester that issued it. Sits between the core's two bus masters and the single-ported program/data memory.

Parameters:
MAX_OUTSTANDING, 4, maximum granted-but-unanswered transactions (power of 2, ≥2).
ARB_MODE, 0, 0 = fixed priority (data over instr); 1 = round-robin between the two.

Ports:
clk  input  1  core clock
reset_n  input  1  reset, synchronous active-low
instr_req  input  1  fetch request
instr_addr  input  32  fetch address
instr_gnt  output  1  fetch request accepted this cycle
instr_rdata  output  32  fetch response data
instr_err  output  1  fetch response error
instr_valid  output  1  fetch response valid
data_req  input  1  LSU request
data_addr  input  32  LSU address
data_we  input  1  LSU write enable
data_be  input  4  LSU byte enables
data_wdata  input  32  LSU write data
data_gnt  output  1  LSU request accepted
data_rdata  output  32  LSU response data
data_err  output  1  LSU response error
data_valid  output  1  LSU response valid
mem_req  output  1  memory request
mem_addr  output  32  memory address
mem_we  output  1  memory write enable
mem_be  output  4  memory byte enables
mem_wdata  output  32  memory write data
mem_gnt  input  1  memory accepted request
mem_rdata  input  32  memory response data
mem_err  input  1  memory response error
mem_valid  input  1  memory response valid (≥1 cycle after gnt, in order)
outstanding  output  $clog2(MAX_OUTSTANDING+1)  current in-flight count
resp_orphan  output  1  sticky: mem_valid seen with nothing outstanding

Behaviour:
- Reset (reset_n low at clk edge): FSM=ARB_IDLE, outstanding=0, ID FIFO empty, resp_orphan=0, RR last-winner=instr (data favoured first). All *_gnt, *_valid, mem_req are combinational and read 0 while reset_n low.
- Request path is zero-latency: mem_req/addr/we/be/wdata and *_gnt are combinational from the selected requester and mem_gnt.
- Instr selected: mem_we=0, mem_be=4'hF, mem_wdata=0. Data selected: LSU fields passed through.
- full = (outstanding==MAX_OUTSTANDING). When full, mem_req=0 and no grant, even if a response arrives the same cycle (no bypass).
- FSM ARB_IDLE: if not full and any req, pick winner (ARB_MODE 0: data; ARB_MODE 1: the one not last granted if both request, else the sole requester). Drive mem_req. If mem_gnt: grant the winner, push its ID, stay IDLE. Else latch owner, go to ARB_LOCK.
- FSM ARB_LOCK: selection frozen to owner regardless of the other req. On mem_gnt: grant owner, push ID, go to IDLE. If owner's req drops (protocol violation): mem_req=0, go to IDLE, no push.
- RR last-winner updates only on an actual grant.
- Response path: on mem_valid with FIFO non-empty, route rdata/err/valid to the head ID and pop. The non-selected side's valid=0 and rdata=0.
- mem_valid with FIFO empty: drop it, set resp_orphan=1 (cleared only by reset).
- Same-cycle grant and response: push and pop both occur; outstanding unchanged.
- outstanding = push − pop accounting. Never exceeds MAX_OUTSTANDING and never underflows.
- Reset mid-operation clears tracking. Responses arriving afterwards are orphans.

Test Plan:
1. ARB_MODE=0, both req every cycle, mem_gnt=1 constant, mem_valid 1 cycle later → data granted every cycle, instr_gnt=0 throughout; data_valid follows each grant by 1 cycle.
2. ARB_MODE=1, both req, mem_gnt=1 → grants alternate data, instr, data, instr. instr_rdata=0x00000013 is returned only on instr_valid.
3. Data wins IDLE with mem_gnt=0 for 3 cycles, instr_req asserted meanwhile → FSM in LOCK; mem_addr stays data_addr=0x2000; on cycle-4 gnt data_gnt=1, then instr is granted next.
4. MAX_OUTSTANDING=4, instr_req held, mem_gnt=1, no mem_valid → 4 grants, outstanding=4, mem_req=0. One mem_valid → outstanding=3, next cycle grant resumes.
5. Interleaved grants instr,data,instr then 3 responses 0xA,0xB,0xC → instr gets 0xA, data 0xB, instr 0xC; mem_err=1 on the 2nd response → data_err=1 only.
6. mem_valid with outstanding=0 → no *_valid, resp_orphan=1 and stays 1. reset_n=0 for 1 cycle → resp_orphan=0, outstanding=0.
